multi_edge_det: RTL

- Parametrised, multi-channel successor to the single-bit positive-edge detector used around the DP/CTRL FSMs.
- Each channel:
  - optionally synchronises an asynchronous input;
  - detects rising, falling or both edges, selected per channel at run time;
  - stretches the detection pulse to a programmable length;
  - keeps a sticky event flag and a saturating event counter.
- Sits between status/handshake sources and the control FSMs.
- With SYNC_STAGES=0, PULSE_LEN=1 and mode RISE, the pulse output is cycle-identical to the legacy detector.

---
 rtl/edge_det_pkg.sv | 18 +
 rtl/edge_det_ch.sv | 121 ++++++++++++
 rtl/multi_edge_det.sv | 49 ++++
 3 files changed

// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
//   edge_mode_t : per-channel detection mode (OFF / RISE / FALL / BOTH)
//   st_width()  : width of the pulse-stretch counter for a given pulse length
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    // Counter must hold PULSE_LEN-1; never narrower than one bit.
    function automatic int unsigned st_width(input int unsigned pulse_len);
        return (pulse_len > 1) ? $clog2(pulse_len) : 1;
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One edge-detector channel: optional synchroniser, previous-sample register, mode-selected
// edge decode, pulse stretcher, sticky flag and saturating event counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_i     : monitored signal
//   mode_i     : detection mode (edge_mode_t encoding)
//   clr_i      : synchronous clear of flag_o and cnt_o
//   pulse_o    : detection pulse, PULSE_LEN cycles per hit
//   flag_o     : sticky "edge seen since last clear"
//   cnt_o      : saturating edge count
module edge_det_ch
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             pulse_o,
    output logic             flag_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned     ST_W      = st_width(PULSE_LEN);
    localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(PULSE_LEN - 1);

    logic             s;
    logic             prev_q, prev_d;
    logic [ST_W-1:0]  st_q, st_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise, fall, hit;
    edge_mode_t       mode;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d[0] = data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign s = data_i;
    end

    assign mode = edge_mode_t'(mode_i);
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        hit = 1'b0;
        unique case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
        endcase
    end

    always_comb begin
        // prev tracks s regardless of mode so a mode change never fakes an edge
        prev_d = s;

        st_d = st_q;
        if (hit) begin
            st_d = ST_RELOAD;
        end else if (st_q != '0) begin
            st_d = st_q - 1'b1;
        end

        // set wins over clear
        flag_d = flag_q;
        if (hit) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            st_q   <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            st_q   <= st_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pulse_o = hit | (st_q != '0);
    assign flag_o  = flag_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/multi_edge_det.sv
// Multi-channel edge detector: N_CH independent edge_det_ch instances plus an OR of all pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : monitored signals, one per channel
//   mode_i     : per-channel mode, bits [2c+1:2c] for channel c
//   clr_i      : per-channel clear of flag_o / evt_cnt_o
//   pulse_o    : per-channel stretched detection pulse
//   flag_o     : per-channel sticky edge flag
//   any_o      : OR of pulse_o
//   evt_cnt_o  : per-channel saturating counts, channel c at [CNT_W*(c+1)-1 : CNT_W*c]
module multi_edge_det
    import edge_det_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       data_in,
    input  logic [2*N_CH-1:0]     mode_i,
    input  logic [N_CH-1:0]       clr_i,
    output logic [N_CH-1:0]       pulse_o,
    output logic [N_CH-1:0]       flag_o,
    output logic                  any_o,
    output logic [N_CH*CNT_W-1:0] evt_cnt_o
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        edge_det_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .PULSE_LEN  (PULSE_LEN),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .data_i (data_in[c]),
            .mode_i (mode_i[2*c +: 2]),
            .clr_i  (clr_i[c]),
            .pulse_o(pulse_o[c]),
            .flag_o (flag_o[c]),
            .cnt_o  (evt_cnt_o[CNT_W*c +: CNT_W])
        );
    end

    assign any_o = |pulse_o;

endmodule
